// File: rtl/load_store_queue_pkg.sv
// load_store_queue_pkg: shared widths, access-size codes, FSM states and lane helpers for the load/store queue.
package load_store_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] LSQ_B  = 3'b000;
  localparam logic [2:0] LSQ_H  = 3'b001;
  localparam logic [2:0] LSQ_W  = 3'b010;
  localparam logic [2:0] LSQ_BU = 3'b100;
  localparam logic [2:0] LSQ_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} lsq_state_e;
  typedef struct packed {
    logic            is_load;
    logic [2:0]      funct3;
    logic [4:0]      regd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } lsq_entry_t;
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ofs);
    return f3[1] ? 4'b1111 : (f3[0] ? 4'b0011 : 4'b0001) << ofs;
  endfunction
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    return f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
  // funct3[2] selects zero-extension by masking the sign bit
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] ofs,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    sh = rdata >> {ofs, 3'b000};
    return f3[1] ? sh : f3[0] ? {{16{sh[15] & ~f3[2]}}, sh[15:0]} : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
  endfunction
endpackage

// File: rtl/load_store_queue_if.sv
// load_store_queue_if: data-memory request/response bus between the queue (master) and memory (slave).
interface load_store_queue_if;
  import load_store_queue_pkg::*;
  logic            req;
  logic            ready;
  logic            wr;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic            rerr;
  logic [XLEN-1:0] rdata;
  modport master (output req, wr, addr, be, wdata, input ready, rvalid, rerr, rdata);
  modport slave  (input req, wr, addr, be, wdata, output ready, rvalid, rerr, rdata);
endinterface

// File: rtl/load_store_queue_fifo.sv
// lsq_fifo: DEPTH-entry in-order buffer of load/store entries with registered occupancy count.
module lsq_fifo
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       resetb_i,
  input  logic       push,
  input  logic       pop,
  input  lsq_entry_t din,
  output lsq_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  lsq_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge resetb_i)
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue issuing one memory transaction at a time with load write-back.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                clk_en_i,
  input  logic                resetb_i,
  input  logic                exs_lq_wr_i,
  input  logic                exs_sq_wr_i,
  input  logic [2:0]          exs_funct3_i,
  input  logic [4:0]          exs_regd_addr_i,
  input  logic [XLEN-1:0]     exs_regs2_data_i,
  input  logic [XLEN-1:0]     exs_addr_i,
  output logic                exs_full_o,
  load_store_queue_if.master  dmem,
  output logic                regd_wr_o,
  output logic [4:0]          regd_addr_o,
  output logic [XLEN-1:0]     regd_data_o,
  output logic                hvec_laf_o,
  output logic                hvec_saf_o,
  output logic [XLEN-1:0]     hvec_fault_addr_o
);
  lsq_state_e state, next_state;
  lsq_entry_t head;
  logic       empty, push, resp;
  assign push = clk_en_i & (exs_lq_wr_i | exs_sq_wr_i) & ~exs_full_o;
  assign resp = clk_en_i & (state == ST_WAIT) & dmem.rvalid;
  lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .push     (push),
    .pop      (resp),
    .din      ('{is_load: exs_lq_wr_i, funct3: exs_funct3_i, regd: exs_regd_addr_i,
                 addr: exs_addr_i, data: exs_regs2_data_i}),
    .head     (head),
    .full     (exs_full_o),
    .empty    (empty)
  );
  always_ff @(posedge clk_i or negedge resetb_i)
    if (!resetb_i) state <= ST_IDLE;
    else if (clk_en_i) state <= next_state;
  always_comb begin
    next_state = state == ST_IDLE ? (empty ? ST_IDLE : ST_REQ) :
                 state == ST_REQ  ? (dmem.ready ? ST_WAIT : ST_REQ) :
                 state == ST_WAIT ? (dmem.rvalid ? ST_IDLE : ST_WAIT) : ST_IDLE;
  end
  assign dmem.req          = clk_en_i & (state == ST_REQ);
  assign dmem.wr           = ~head.is_load;
  assign dmem.addr         = {head.addr[XLEN-1:2], 2'b00};
  assign dmem.be           = store_be(head.funct3, head.addr[1:0]);
  assign dmem.wdata        = store_wdata(head.funct3, head.data);
  assign regd_wr_o         = resp & ~dmem.rerr & head.is_load;
  assign regd_addr_o       = head.regd;
  assign regd_data_o       = load_extend(head.funct3, head.addr[1:0], dmem.rdata);
  assign hvec_laf_o        = resp & dmem.rerr & head.is_load;
  assign hvec_saf_o        = resp & dmem.rerr & ~head.is_load;
  assign hvec_fault_addr_o = head.addr;
endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: scoreboard bench with a one-outstanding memory responder for load_store_queue.
module tb_load_store_queue;
  import load_store_queue_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, data, rdata;
    logic        rerr;
    logic [3:0]  be;
    logic [31:0] wdata, ld;
  } exp_t;
  logic clk = 0, clk_en = 1, resetb = 0, lq_wr = 0, sq_wr = 0;
  logic [2:0]  f3 = 0;
  logic [4:0]  rd = 0;
  logic [31:0] sdata = 0, addr = 0;
  logic        full, regd_wr, laf, saf;
  logic [4:0]  regd_addr;
  logic [31:0] regd_data, fault_addr;
  exp_t sb[$];
  exp_t e_mon;
  int   mcount = 0, n_err = 0, n_chk = 0;
  logic acc = 0, cons = 0;
  load_store_queue_if dmem();
  load_store_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb),
    .exs_lq_wr_i(lq_wr), .exs_sq_wr_i(sq_wr), .exs_funct3_i(f3), .exs_regd_addr_i(rd),
    .exs_regs2_data_i(sdata), .exs_addr_i(addr), .exs_full_o(full), .dmem(dmem.master),
    .regd_wr_o(regd_wr), .regd_addr_o(regd_addr), .regd_data_o(regd_data),
    .hvec_laf_o(laf), .hvec_saf_o(saf), .hvec_fault_addr_o(fault_addr));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [1:0] a);
    case (fn[1:0])
      2'b00:   return a == 0 ? 4'b0001 : a == 1 ? 4'b0010 : a == 2 ? 4'b0100 : 4'b1000;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
    case (fn[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [1:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (fn)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return r;
    endcase
  endfunction
  always @(negedge clk) begin
    acc = 0;
    cons = 0;
    if (!resetb) check("rst_out", {27'b0, dmem.req, regd_wr, laf, saf, full}, 0);
    else begin
      if (!clk_en) check("gated", {28'b0, dmem.req, regd_wr, laf, saf}, 0);
      if (dmem.req && dmem.ready) begin
        acc = 1;
        if (sb.size() == 0) check("req_unexp", dmem.req, 0);
        else begin
          check("req_wr", dmem.wr, !sb[0].is_load);
          check("req_addr", dmem.addr, {sb[0].addr[31:2], 2'b00});
          if (!sb[0].is_load) begin
            check("req_be", dmem.be, sb[0].be);
            check("req_wdata", dmem.wdata, sb[0].wdata);
          end
        end
      end
      if (dmem.rvalid && clk_en) begin
        cons = 1;
        if (sb.size() == 0) check("rsp_unexp", dmem.rvalid, 0);
        else begin
          e_mon = sb.pop_front();
          mcount--;
          check("regd_wr", regd_wr, e_mon.is_load && !e_mon.rerr);
          check("laf", laf, e_mon.is_load && e_mon.rerr);
          check("saf", saf, !e_mon.is_load && e_mon.rerr);
          if (e_mon.is_load && !e_mon.rerr) begin
            check("regd_addr", regd_addr, e_mon.rd);
            check("regd_data", regd_data, e_mon.ld);
          end
          if (e_mon.rerr) check("fault_addr", fault_addr, e_mon.addr);
        end
      end else if (clk_en) check("no_strobe", {29'b0, regd_wr, laf, saf}, 0);
    end
  end
  initial begin
    dmem.rvalid = 0;
    dmem.rerr = 0;
    dmem.rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetb) dmem.rvalid = 0;
      else begin
        if (cons) dmem.rvalid = 0;
        if (acc && sb.size() > 0) begin
          dmem.rvalid = 1;
          dmem.rdata = sb[0].rdata;
          dmem.rerr = sb[0].rerr;
        end
      end
      if (!dmem.rvalid) begin
        dmem.rdata = $urandom;
        dmem.rerr = 1'($urandom_range(0, 1));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_op(input logic ld, input logic [2:0] fn, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat, input logic err);
    exp_t e;
    e.is_load = ld; e.f3 = fn; e.rd = r; e.addr = a; e.data = d; e.rdata = rdat; e.rerr = err;
    e.be = m_be(fn, a[1:0]);
    e.wdata = m_wdata(fn, d);
    e.ld = m_load(fn, a[1:0], rdat);
    check("full", full, mcount == DEPTH);
    lq_wr = ld; sq_wr = !ld; f3 = fn; rd = r; addr = a; sdata = d;
    if (mcount < DEPTH && clk_en) begin
      sb.push_back(e);
      mcount++;
    end
    tick();
    lq_wr = 0;
    sq_wr = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) tick();
    check("drain", sb.size(), 0);
    tick();
    check("idle_full", full, 0);
  endtask
  task automatic wait_rvalid();
    for (int i = 0; i < 30 && !dmem.rvalid; i++) tick();
    check("wait_rvalid", dmem.rvalid, 1);
  endtask
  initial begin
    logic [2:0] fns [5];
    fns = '{LSQ_B, LSQ_H, LSQ_W, LSQ_BU, LSQ_HU};
    dmem.ready = 1;
    repeat (2) tick();
    resetb = 1;
    tick();
    push_op(0, LSQ_W, 0, 32'h100, 32'hDEADBEEF, 0, 0);
    drain();
    push_op(1, LSQ_B, 5, 32'h103, 0, 32'h80FFFFFF, 0);
    push_op(1, LSQ_BU, 6, 32'h103, 0, 32'h80FFFFFF, 0);
    push_op(1, LSQ_HU, 7, 32'h102, 0, 32'h80FFFFFF, 0);
    push_op(1, LSQ_H, 8, 32'h100, 0, 32'h12348001, 0);
    drain();
    push_op(1, LSQ_W, 0, 32'h104, 0, 32'h13572468, 0);
    push_op(0, LSQ_H, 0, 32'h206, 32'h00001234, 0, 0);
    push_op(0, LSQ_B, 0, 32'h201, 32'h000000AB, 0, 0);
    drain();
    dmem.ready = 0;
    for (int i = 0; i < 5; i++) push_op(1, LSQ_W, 5'(i + 1), 32'h400 + 32'(4 * i), 0, 32'h1000 + 32'(i), 0);
    check("full_hold", full, 1);
    dmem.ready = 1;
    for (int i = 0; i < 30 && sb.size() > 3; i++) tick();
    check("full_after_pop", full, 0);
    drain();
    push_op(1, LSQ_W, 9, 32'h300, 0, 32'hCAFEF00D, 1);
    push_op(0, LSQ_W, 0, 32'h304, 32'h55AA55AA, 0, 0);
    drain();
    push_op(0, LSQ_B, 0, 32'h30B, 32'h000000EE, 0, 1);
    drain();
    dmem.ready = 0;
    for (int i = 0; i < 3; i++) push_op(1, LSQ_HU, 5'(10 + i), 32'h500 + 32'(4 * i), 0, 32'hBEEF0000 + 32'(i), 0);
    dmem.ready = 1;
    wait_rvalid();
    push_op(1, LSQ_B, 13, 32'h511, 0, 32'h0000F700, 0);
    check("pushpop_full", full, 0);
    drain();
    push_op(1, LSQ_H, 14, 32'h602, 0, 32'hF00D0000, 0);
    wait_rvalid();
    clk_en = 0;
    repeat (3) tick();
    check("frozen", sb.size(), 1);
    clk_en = 1;
    drain();
    for (int i = 0; i < 20; i++) begin
      logic ld;
      logic [2:0] fn;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      fn = ld ? fns[$urandom_range(0, 4)] : fns[$urandom_range(0, 2)];
      a = 32'h800 + 32'(4 * i);
      if (fn[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      else if (fn[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
      dmem.ready = 1'($urandom_range(0, 1));
      push_op(ld, fn, 5'($urandom), a, $urandom, $urandom, $urandom_range(0, 7) == 0);
    end
    dmem.ready = 1;
    drain();
    push_op(1, LSQ_W, 15, 32'h700, 0, 32'h11111111, 0);
    wait_rvalid();
    resetb = 0;
    sb.delete();
    mcount = 0;
    tick();
    check("rst_full", full, 0);
    check("rst_req", dmem.req, 0);
    resetb = 1;
    tick();
    push_op(0, LSQ_W, 0, 32'h704, 32'h87654321, 0, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
